// File: rtl/bus_target_pkg.sv
// Shared definitions for the bus_target responder slice.
// Holds the FSM state encodings, default bus widths and the wait-counter
// sizing used by bus_target and bus_regfile.
package bus_target_pkg;

  localparam int unsigned DEF_WIDTH       = 4;
  localparam int unsigned DEF_AWIDTH      = 2;
  localparam int unsigned CNT_W           = 4;
  localparam int unsigned MAX_WAIT_STATES = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_TURN = 2'd3
  } bus_state_e;

  // Counter preload on accept: the WAIT state is left when the counter
  // reads zero, so WAIT_STATES wait cycles need a preload of WAIT_STATES-1.
  function automatic logic [CNT_W-1:0] wait_load(input int unsigned ws);
    logic [CNT_W-1:0] v;
    v = '0;
    if (ws != 0) v = CNT_W'(ws - 1);
    return v;
  endfunction

endpackage

// File: rtl/bus_regfile.sv
// Register file behind the bus target.
// Ports:
//   Clk     - clock, writes on posedge
//   Reset_l - asynchronous active-low reset, clears every entry
//   we      - write enable
//   waddr   - write index
//   wdata   - write data
//   raddr   - read index (combinational read)
//   rdata   - read data
module bus_regfile
  import bus_target_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned AWIDTH = DEF_AWIDTH
) (
  input  logic              Clk,
  input  logic              Reset_l,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [AWIDTH-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  localparam int unsigned DEPTH = 1 << AWIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge Clk or negedge Reset_l) begin
    if (!Reset_l) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bus_target.sv
// Responder on the shared tri-state data bus.
// Decodes a cycle request, waits WAIT_STATES cycles, pulses Ack_l for one
// clock, then spends one turnaround cycle before accepting again.
// Ports:
//   Clk     - bus clock, all state changes on posedge
//   Reset_l - asynchronous active-low reset
//   Sel_l   - cycle request (active low), sampled on posedge
//   WE_l    - 0 = write, 1 = read, sampled with Sel_l
//   Addr    - register index, sampled with Sel_l
//   Data    - tri-state data; driven only in the ACK cycle of a read
//   Ack_l   - completion strobe (active low), one clock wide
//   State   - debug view of the FSM state (bus_state_e encoding)
//
// Handshake: a request is accepted on the posedge where the FSM is IDLE and
// Sel_l is 0. The initiator must keep Sel_l low through the WAIT cycles;
// Sel_l high on a WAIT edge cancels the cycle with no Ack and no write.
// Ack_l low for exactly one cycle marks completion; during that cycle read
// data is valid on Data. Sel_l is ignored in ACK and TURN.
module bus_target
  import bus_target_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned AWIDTH      = DEF_AWIDTH,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              Clk,
  input  logic              Reset_l,
  input  logic              Sel_l,
  input  logic              WE_l,
  input  logic [AWIDTH-1:0] Addr,
  inout  wire  [WIDTH-1:0]  Data,
  output logic              Ack_l,
  output logic [1:0]        State
);

  if (WAIT_STATES > MAX_WAIT_STATES) begin : g_bad_wait_states
    $error("bus_target: WAIT_STATES=%0d exceeds the 4-bit counter range", WAIT_STATES);
  end

  localparam logic [CNT_W-1:0] WAIT_LOAD = wait_load(WAIT_STATES);

  bus_state_e        state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              accept;
  logic [AWIDTH-1:0] addr_q;
  logic              we_l_q;
  logic [WIDTH-1:0]  data_q;
  logic              drv_en;
  logic              is_write;
  logic [AWIDTH-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              rf_we;
  logic [WIDTH-1:0]  rd_data;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    case (state)
      ST_IDLE: begin
        // Only a clean 0 accepts; 1 or x leaves the target idle.
        if (Sel_l == 1'b0) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_nx = ST_ACK;
          end else begin
            state_nx = ST_WAIT;
            cnt_nx   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (Sel_l == 1'b1) begin
          state_nx = ST_IDLE;
        end else if (cnt == '0) begin
          state_nx = ST_ACK;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      ST_ACK:  state_nx = ST_TURN;
      ST_TURN: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // With zero wait states ACK is entered straight from IDLE, before the
  // request has been latched, so the write path takes the live bus inputs.
  assign is_write = (state == ST_IDLE) ? ~WE_l : ~we_l_q;
  assign wr_addr  = (state == ST_IDLE) ? Addr  : addr_q;
  assign wr_data  = (state == ST_IDLE) ? Data  : data_q;
  assign rf_we    = (state_nx == ST_ACK) && is_write;

  always_ff @(posedge Clk or negedge Reset_l) begin
    if (!Reset_l) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      addr_q <= '0;
      we_l_q <= 1'b1;
      data_q <= '0;
      Ack_l  <= 1'b1;
      drv_en <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        addr_q <= Addr;
        we_l_q <= WE_l;
        if (!WE_l) data_q <= Data;
      end
      // Both strobes are registered from the next-state decode so the bus
      // never sees a glitch from the request inputs.
      Ack_l  <= (state_nx != ST_ACK);
      drv_en <= (state_nx == ST_ACK) && !is_write;
    end
  end

  bus_regfile #(
    .WIDTH  (WIDTH),
    .AWIDTH (AWIDTH)
  ) u_regfile (
    .Clk     (Clk),
    .Reset_l (Reset_l),
    .we      (rf_we),
    .waddr   (wr_addr),
    .wdata   (wr_data),
    .raddr   (addr_q),
    .rdata   (rd_data)
  );

  assign Data  = drv_en ? rd_data : {WIDTH{1'bz}};
  assign State = state;

endmodule

// File: tb/tb_bus_target.sv
module tb_bus_target;
  import bus_target_pkg::*;

  localparam int W  = 4;
  localparam int AW = 2;
  localparam logic [W-1:0] BUS_FLOAT = 4'hF;  // released bus reads as pulled-up

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------- DUT with one wait state ----------------
  logic          sel_l, we_l;
  logic [AW-1:0] addr;
  logic [W-1:0]  tb_data;
  logic          tb_drv;
  wire  [W-1:0]  data_bus;
  logic          ack_l;
  logic [1:0]    state;

  assign data_bus = tb_drv ? tb_data : {W{1'bz}};
  for (genvar i = 0; i < W; i++) begin : g_pu
    pullup (data_bus[i]);
  end

  bus_target #(.WIDTH(W), .AWIDTH(AW), .WAIT_STATES(1)) dut (
    .Clk     (clk),
    .Reset_l (rst_n),
    .Sel_l   (sel_l),
    .WE_l    (we_l),
    .Addr    (addr),
    .Data    (data_bus),
    .Ack_l   (ack_l),
    .State   (state)
  );

  // ---------------- DUT with zero wait states ----------------
  logic          sel_l0, we_l0;
  logic [AW-1:0] addr0;
  logic [W-1:0]  tb_data0;
  logic          tb_drv0;
  wire  [W-1:0]  data_bus0;
  logic          ack_l0;
  logic [1:0]    state0;

  assign data_bus0 = tb_drv0 ? tb_data0 : {W{1'bz}};
  for (genvar i = 0; i < W; i++) begin : g_pu0
    pullup (data_bus0[i]);
  end

  bus_target #(.WIDTH(W), .AWIDTH(AW), .WAIT_STATES(0)) dut0 (
    .Clk     (clk),
    .Reset_l (rst_n),
    .Sel_l   (sel_l0),
    .WE_l    (we_l0),
    .Addr    (addr0),
    .Data    (data_bus0),
    .Ack_l   (ack_l0),
    .State   (state0)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic         kind_q[$];   // 1 = read, 0 = write, one entry per accepted cycle
  logic [W-1:0] exp_q[$];    // expected read data, one entry per read
  logic         mon_kind;
  logic [W-1:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ack_l == 1'b0) begin
        if (kind_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_ack: got ack_l 0 expected 1 at %0t", $time);
        end else begin
          mon_kind = kind_q.pop_front();
          if (mon_kind) begin
            mon_exp = exp_q.pop_front();
            check("read_data", data_bus, mon_exp);
          end else begin
            check("write_ack_bus_released", data_bus, BUS_FLOAT);
          end
        end
      end else if (!tb_drv) begin
        check("bus_released_ack_high", data_bus, BUS_FLOAT);
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic          we_n;
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    logic [W-1:0]  exp;
    logic          hold;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  // ---------------- driver tasks ----------------
  // One full cycle on the WAIT_STATES=1 target, with the timing of every
  // phase checked: accept edge, WAIT, ACK, TURN.
  task automatic bus_cycle(input logic we_n, input logic [AW-1:0] a, input logic [W-1:0] d,
                           input logic [W-1:0] exp, input logic hold, input string tag);
    @(negedge clk);
    sel_l   = 1'b0;
    we_l    = we_n;
    addr    = a;
    tb_data = d;
    tb_drv  = ~we_n;
    @(posedge clk);
    kind_q.push_back(we_n);
    if (we_n) exp_q.push_back(exp);
    #1;
    addr    = AW'($urandom_range(0, 3));
    we_l    = 1'($urandom_range(0, 1));
    tb_data = W'($urandom_range(0, 15));
    tb_drv  = 1'b0;
    @(negedge clk);
    check({tag, " wait ack_l"}, ack_l, 1'b1);
    check({tag, " wait state"}, state, ST_WAIT);
    @(posedge clk);
    #1;
    if (!hold) sel_l = 1'b1;
    @(negedge clk);
    check({tag, " ack ack_l"}, ack_l, 1'b0);
    check({tag, " ack state"}, state, ST_ACK);
    @(posedge clk);
    @(negedge clk);
    check({tag, " turn ack_l"}, ack_l, 1'b1);
    check({tag, " turn state"}, state, ST_TURN);
    @(posedge clk);
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [W-1:0] d, input logic hold);
    bus_cycle(1'b0, a, d, '0, hold, "write");
  endtask

  task automatic bus_read(input logic [AW-1:0] a, input logic [W-1:0] exp, input logic hold);
    bus_cycle(1'b1, a, '0, exp, hold, "read");
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (vecs[i].we_n) bus_read(vecs[i].a, vecs[i].exp, vecs[i].hold);
      else              bus_write(vecs[i].a, vecs[i].d, vecs[i].hold);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // reads after reset
    vecs[0]  = '{1'b1, 2'd0, 4'h0, 4'h0, 1'b0};
    vecs[1]  = '{1'b1, 2'd1, 4'h0, 4'h0, 1'b0};
    vecs[2]  = '{1'b1, 2'd2, 4'h0, 4'h0, 1'b0};
    vecs[3]  = '{1'b1, 2'd3, 4'h0, 4'h0, 1'b0};
    // write then read back
    vecs[4]  = '{1'b0, 2'd2, 4'hA, 4'h0, 1'b0};
    vecs[5]  = '{1'b1, 2'd2, 4'h0, 4'hA, 1'b0};
    // mixed traffic
    vecs[6]  = '{1'b0, 2'd0, 4'h3, 4'h0, 1'b0};
    vecs[7]  = '{1'b0, 2'd3, 4'hC, 4'h0, 1'b0};
    vecs[8]  = '{1'b1, 2'd0, 4'h0, 4'h3, 1'b0};
    vecs[9]  = '{1'b1, 2'd3, 4'h0, 4'hC, 1'b0};
    vecs[10] = '{1'b0, 2'd0, 4'h6, 4'h0, 1'b0};
    vecs[11] = '{1'b1, 2'd0, 4'h0, 4'h6, 1'b0};
    vecs[12] = '{1'b1, 2'd1, 4'h0, 4'h0, 1'b0};
    // back-to-back reads with Sel_l held low
    vecs[13] = '{1'b1, 2'd0, 4'h0, 4'h6, 1'b1};
    vecs[14] = '{1'b1, 2'd1, 4'h0, 4'h0, 1'b1};
    vecs[15] = '{1'b1, 2'd2, 4'h0, 4'hA, 1'b1};
    vecs[16] = '{1'b1, 2'd3, 4'h0, 4'hC, 1'b0};
    // write immediately followed by read of the same register
    vecs[17] = '{1'b0, 2'd1, 4'h9, 4'h0, 1'b1};
    vecs[18] = '{1'b1, 2'd1, 4'h0, 4'h9, 1'b0};
    // after mid-cycle reset every register is back to 0
    vecs[19] = '{1'b1, 2'd2, 4'h0, 4'h0, 1'b0};
    vecs[20] = '{1'b1, 2'd1, 4'h0, 4'h0, 1'b0};

    sel_l = 1'b1; we_l = 1'b1; addr = '0; tb_data = '0; tb_drv = 1'b0;
    sel_l0 = 1'b1; we_l0 = 1'b1; addr0 = '0; tb_data0 = '0; tb_drv0 = 1'b0;
    rst_n = 1'b1;
    #5  rst_n = 1'b0;
    #20 rst_n = 1'b1;

    @(negedge clk);
    check("reset ack_l", ack_l, 1'b1);
    check("reset state", state, ST_IDLE);
    check("reset data", data_bus, BUS_FLOAT);
    check("reset ack_l ws0", ack_l0, 1'b1);
    check("reset state ws0", state0, ST_IDLE);

    run_vecs(0, 12);

    // abort: accept a write to reg 1, then drop Sel_l before the WAIT edge
    @(negedge clk);
    sel_l = 1'b0; we_l = 1'b0; addr = 2'd1; tb_data = 4'h5; tb_drv = 1'b1;
    @(posedge clk);
    #1;
    sel_l = 1'b1; tb_drv = 1'b0;
    @(negedge clk);
    check("abort wait state", state, ST_WAIT);
    @(negedge clk);
    check("abort back to idle", state, ST_IDLE);
    check("abort no ack", ack_l, 1'b1);
    @(negedge clk);
    check("abort still no ack", ack_l, 1'b1);
    bus_read(2'd1, 4'h0, 1'b0);

    run_vecs(13, 18);

    // reset during the ACK cycle of a read of reg 2 (holds 4'hA)
    @(negedge clk);
    sel_l = 1'b0; we_l = 1'b1; addr = 2'd2; tb_drv = 1'b0;
    @(posedge clk);
    kind_q.push_back(1'b1);
    exp_q.push_back(4'hA);
    #1;
    addr = 2'd3;
    @(posedge clk);
    #1;
    sel_l = 1'b1;
    @(negedge clk);
    check("midreset pre ack_l", ack_l, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("midreset ack_l", ack_l, 1'b1);
    check("midreset data", data_bus, BUS_FLOAT);
    check("midreset state", state, ST_IDLE);
    #5 rst_n = 1'b1;

    run_vecs(19, 20);

    // zero wait states: write 4'hA to reg 2, then read it back
    @(negedge clk);
    sel_l0 = 1'b0; we_l0 = 1'b0; addr0 = 2'd2; tb_data0 = 4'hA; tb_drv0 = 1'b1;
    @(posedge clk);
    #1;
    sel_l0 = 1'b1; tb_drv0 = 1'b0; addr0 = 2'd0; tb_data0 = 4'h0;
    @(negedge clk);
    check("ws0 write ack_l", ack_l0, 1'b0);
    check("ws0 write state", state0, ST_ACK);
    check("ws0 write bus released", data_bus0, BUS_FLOAT);
    @(negedge clk);
    check("ws0 turn ack_l", ack_l0, 1'b1);
    check("ws0 turn state", state0, ST_TURN);
    @(negedge clk);
    sel_l0 = 1'b0; we_l0 = 1'b1; addr0 = 2'd2;
    @(posedge clk);
    #1;
    sel_l0 = 1'b1; addr0 = 2'd1;
    @(negedge clk);
    check("ws0 read ack_l", ack_l0, 1'b0);
    check("ws0 read data", data_bus0, 4'hA);
    @(negedge clk);
    check("ws0 read turn ack_l", ack_l0, 1'b1);
    check("ws0 read turn data", data_bus0, BUS_FLOAT);

    @(negedge clk);
    check("kind_q drained", kind_q.size(), 0);
    check("exp_q drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
